// File: rtl/key_event_pkg.sv
// key_event_pkg: event type, WASD keycodes and emitter states shared by the key event queue.
package key_event_pkg;

    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } key_event_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REL0,
        ST_REL1,
        ST_PRS0,
        ST_PRS1
    } key_state_t;

    function automatic logic in_snapshot(input logic [7:0] code, input logic [15:0] snap);
        return (code == snap[7:0]) || (code == snap[15:8]);
    endfunction

    function automatic logic [3:0] wasd_mask(input logic [15:0] snap);
        return {in_snapshot(KEY_W, snap), in_snapshot(KEY_A, snap),
                in_snapshot(KEY_S, snap), in_snapshot(KEY_D, snap)};
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: power-of-two event FIFO; a push while full is taken only if a pop happens too.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  key_event_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output key_event_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

    key_event_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is clean without resetting storage.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: debounces a two-slot keycode into snapshots and queues press/release events.
// Define KEY_EVENT_REPEAT_EN to add auto-repeat of the slot-0 key.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter logic [15:0] STABLE_CYCLES = 16'd50000,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [23:0] REPEAT_DELAY  = 24'd25000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd5000000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [8:0]  ev_data,
    output logic [3:0]  held_dir,
    output logic        overflow
);

    localparam logic [15:0] STABLE_LAST = STABLE_CYCLES - 16'd1;

    key_state_t  state;
    key_state_t  state_next;
    logic [15:0] prev_key;
    logic [15:0] stable_cnt;
    logic [15:0] stable_cnt_next;
    logic [15:0] snapshot;
    logic [15:0] old_snap;
    logic        accept;
    logic        fsm_push;
    key_event_t  fsm_ev;
    logic        rep_push;
    logic        push;
    key_event_t  push_ev;
    logic        pop;
    logic        full;
    logic        empty;
    key_event_t  head;

    // Counter saturates so a snapshot that matured while busy is taken on return to IDLE.
    always_comb begin
        stable_cnt_next = '0;
        if (keycode == prev_key)
            stable_cnt_next = (stable_cnt == STABLE_LAST) ? stable_cnt : stable_cnt + 16'd1;
    end

    assign accept = (state == ST_IDLE) && (stable_cnt_next == STABLE_LAST) && (keycode != snapshot);

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Releases compare old codes against the new snapshot, presses the reverse.
    always_comb begin
        state_next = state;
        fsm_push   = 1'b0;
        fsm_ev     = '0;
        case (state)
            ST_IDLE: if (accept) state_next = ST_REL0;
            ST_REL0: begin
                state_next = ST_REL1;
                fsm_ev     = {1'b0, old_snap[7:0]};
                fsm_push   = (old_snap[7:0] != 8'h00) && !in_snapshot(old_snap[7:0], snapshot);
            end
            ST_REL1: begin
                state_next = ST_PRS0;
                fsm_ev     = {1'b0, old_snap[15:8]};
                fsm_push   = (old_snap[15:8] != 8'h00) && (old_snap[15:8] != old_snap[7:0])
                             && !in_snapshot(old_snap[15:8], snapshot);
            end
            ST_PRS0: begin
                state_next = ST_PRS1;
                fsm_ev     = {1'b1, snapshot[7:0]};
                fsm_push   = (snapshot[7:0] != 8'h00) && !in_snapshot(snapshot[7:0], old_snap);
            end
            ST_PRS1: begin
                state_next = ST_IDLE;
                fsm_ev     = {1'b1, snapshot[15:8]};
                fsm_push   = (snapshot[15:8] != 8'h00) && (snapshot[15:8] != snapshot[7:0])
                             && !in_snapshot(snapshot[15:8], old_snap);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            prev_key   <= '0;
            stable_cnt <= '0;
            snapshot   <= '0;
            old_snap   <= '0;
            held_dir   <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_key   <= keycode;
            stable_cnt <= stable_cnt_next;
            if (accept) begin
                old_snap <= snapshot;
                snapshot <= keycode;
            end
            held_dir <= wasd_mask(snapshot);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    logic [23:0] rep_cnt;
    logic        rep_first;
    logic        rep_pend;
    logic        rep_due;

    assign rep_due  = (snapshot[7:0] != 8'h00)
                      && (rep_cnt == ((rep_first ? REPEAT_DELAY : REPEAT_PERIOD) - 24'd1));
    // FSM pushes win; a colliding repeat waits in rep_pend for the next free cycle.
    assign rep_push = (rep_due || rep_pend) && !fsm_push && !accept;

    always_ff @(posedge Clk) begin
        if (!Reset_n || accept) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            rep_pend  <= 1'b0;
        end else begin
            rep_cnt  <= rep_due ? '0 : rep_cnt + 24'd1;
            if (rep_due) rep_first <= 1'b0;
            rep_pend <= (rep_due || rep_pend) && fsm_push;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_push = 1'b0;
`endif

    assign push    = fsm_push || rep_push;
    assign push_ev = fsm_push ? fsm_ev : key_event_t'({1'b1, snapshot[7:0]});
    assign pop     = ev_valid && ev_ready;

    key_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .push     (push),
        .push_data(push_ev),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign ev_valid = !empty;
    assign ev_data  = head;

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue against an event-list reference model.
module tb_key_event_queue;

    localparam int STABLE = 4;
    localparam int DEPTH  = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        ev_ready = 1'b1;
    logic        ev_valid;
    logic [8:0]  ev_data;
    logic [3:0]  held_dir;
    logic        overflow;

    key_event_queue #(
        .STABLE_CYCLES(16'd4),
        .FIFO_DEPTH   (4),
        .REPEAT_DELAY (24'd20),
        .REPEAT_PERIOD(24'd10)
    ) dut (
        .Clk     (clk),
        .Reset_n (Reset_n),
        .keycode (keycode),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_data (ev_data),
        .held_dir(held_dir),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    logic [15:0] m_last_key = 16'h0000;
    int          m_run = 1;
    logic [15:0] m_snap = 16'h0000;
    int          m_acc = -1000;
    logic [8:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic [3:0]  m_held = 4'h0;
    bit          m_pend = 1'b0;
    logic [8:0]  fsm_at[int];

    function automatic logic [3:0] wasd(input logic [15:0] s);
        wasd[3] = (s[7:0] == 8'h1A) || (s[15:8] == 8'h1A);
        wasd[2] = (s[7:0] == 8'h04) || (s[15:8] == 8'h04);
        wasd[1] = (s[7:0] == 8'h16) || (s[15:8] == 8'h16);
        wasd[0] = (s[7:0] == 8'h07) || (s[15:8] == 8'h07);
    endfunction

    always @(posedge clk) begin : model
        logic [8:0] ev;
        bit         have, fsm_p, acc, pop, rdue;
        logic [7:0] o0, o1, n0, n1;
        cyc = cyc + 1;
        if (!Reset_n) begin
            m_last_key = 16'h0000;
            m_run      = 1;
            m_snap     = 16'h0000;
            m_acc      = -1000;
            m_q.delete();
            m_ovf      = 1'b0;
            m_held     = 4'h0;
            m_pend     = 1'b0;
            fsm_at.delete();
        end else begin
            m_run      = (keycode == m_last_key) ? m_run + 1 : 1;
            m_last_key = keycode;
            acc   = (cyc > m_acc + 4) && (m_run >= STABLE) && (keycode != m_snap);
            have  = 1'b0;
            ev    = 9'h000;
            fsm_p = fsm_at.exists(cyc);
            if (fsm_p) begin
                ev   = fsm_at[cyc];
                have = 1'b1;
                fsm_at.delete(cyc);
            end
`ifdef KEY_EVENT_REPEAT_EN
            rdue = (m_snap[7:0] != 8'h00) && ((cyc - m_acc) >= DELAY)
                   && (((cyc - m_acc - DELAY) % PERIOD) == 0);
            if ((rdue || m_pend) && !fsm_p && !acc) begin
                ev   = {1'b1, m_snap[7:0]};
                have = 1'b1;
            end
            m_pend = (rdue || m_pend) && fsm_p && !acc;
`else
            rdue = 1'b0;
`endif
            m_held = wasd(m_snap);
            if (acc) begin
                o0 = m_snap[7:0];  o1 = m_snap[15:8];
                n0 = keycode[7:0]; n1 = keycode[15:8];
                if (o0 != 0 && o0 != n0 && o0 != n1)                         fsm_at[cyc+1] = {1'b0, o0};
                if (o1 != 0 && o1 != o0 && o1 != n0 && o1 != n1)             fsm_at[cyc+2] = {1'b0, o1};
                if (n0 != 0 && n0 != o0 && n0 != o1)                         fsm_at[cyc+3] = {1'b1, n0};
                if (n1 != 0 && n1 != n0 && n1 != o0 && n1 != o1)             fsm_at[cyc+4] = {1'b1, n1};
                m_acc  = cyc;
                m_snap = keycode;
            end
            pop = (m_q.size() != 0) && ev_ready;
            if (have && !(m_q.size() < DEPTH || pop)) begin
                m_ovf = 1'b1;
                have  = 1'b0;
            end
            if (pop)  void'(m_q.pop_front());
            if (have) m_q.push_back(ev);
        end
    end

    // ---------------- per-cycle compare and pop log ----------------
    logic [8:0] log_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ev_valid", {8'h0, ev_valid}, {8'h0, m_q.size() != 0});
            check("ev_data", ev_data, (m_q.size() != 0) ? m_q[0] : 9'h000);
            check("held_dir", {5'h0, held_dir}, {5'h0, m_held});
            check("overflow", {8'h0, overflow}, {8'h0, m_ovf});
            if (Reset_n && ev_valid && ev_ready) log_q.push_back(ev_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        keycode = 16'h0000;
        tick(2);
        Reset_n = 1'b1;
        log_q.delete();
    endtask

    logic [15:0] pool [8];
    logic [8:0]  exp4 [4];

    initial begin
        pool = '{16'h0000, 16'h001A, 16'h0004, 16'h1A04, 16'h0716, 16'h1616, 16'h0007, 16'h0416};
        exp4 = '{9'h121, 9'h021, 9'h122, 9'h022};

        tick(3);
        cmp_en = 1'b1;
        check("reset_ev_valid", {8'h0, ev_valid}, 9'h000);
        check("reset_ev_data", ev_data, 9'h000);
        check("reset_held_dir", {5'h0, held_dir}, 9'h000);
        check("reset_overflow", {8'h0, overflow}, 9'h000);
        Reset_n  = 1'b1;
        ev_ready = 1'b1;

        // Single W press.
        keycode = 16'h001A;
        tick(12);
        check("w_count", 9'(log_q.size()), 9'd1);
        if (log_q.size() >= 1) check("w_event", log_q[0], 9'h11A);
        check("w_held", {5'h0, held_dir}, 9'h008);

        // Bouncing input never settles.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            keycode = i[0] ? 16'h0000 : 16'h001A;
            tick(2);
        end
        keycode = 16'h0000;
        tick(6);
        check("bounce_count", 9'(log_q.size()), 9'd0);
        check("bounce_held", {5'h0, held_dir}, 9'h000);

        // W, then A+D.
        keycode = 16'h001A;
        tick(10);
        keycode = 16'h0704;
        tick(10);
        check("ad_count", 9'(log_q.size()), 9'd4);
        if (log_q.size() == 4) begin
            check("ad_ev0", log_q[0], 9'h11A);
            check("ad_ev1", log_q[1], 9'h01A);
            check("ad_ev2", log_q[2], 9'h104);
            check("ad_ev3", log_q[3], 9'h107);
        end
        check("ad_held", {5'h0, held_dir}, 9'h005);

        // Overflow with consumer stalled.
        do_reset();
        ev_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            keycode = {8'h00, 8'h20 + 8'(k)};
            tick(10);
        end
        check("ovf_flag", {8'h0, overflow}, 9'h001);
        check("ovf_valid", {8'h0, ev_valid}, 9'h001);
        log_q.delete();
        ev_ready = 1'b1;
        tick(8);
        check("ovf_count", 9'(log_q.size()), 9'd4);
        if (log_q.size() == 4)
            for (int i = 0; i < 4; i++) check("ovf_order", log_q[i], exp4[i]);

        // Reset while the press state is active.
        keycode = 16'h0004;
        tick(6);
        Reset_n = 1'b0;
        keycode = 16'h0000;
        tick(1);
        check("midrst_valid", {8'h0, ev_valid}, 9'h000);
        check("midrst_held", {5'h0, held_dir}, 9'h000);
        check("midrst_ovf", {8'h0, overflow}, 9'h000);
        Reset_n = 1'b1;
        log_q.delete();
        tick(12);
        check("midrst_count", 9'(log_q.size()), 9'd0);

`ifdef KEY_EVENT_REPEAT_EN
        // S held long enough for three repeats, then released.
        do_reset();
        tick(2);
        keycode = 16'h0016;
        tick(48);
        keycode = 16'h0000;
        tick(20);
        check("rep_count", 9'(log_q.size()), 9'd5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 4; i++) check("rep_press", log_q[i], 9'h116);
            check("rep_release", log_q[4], 9'h016);
        end
`endif

        // Random traffic.
        begin
            int hold = 0;
            for (int c = 0; c < 2000; c++) begin
                if (hold == 0) begin
                    keycode = pool[$urandom_range(0, 7)];
                    hold    = $urandom_range(1, 10);
                end
                hold--;
                if ((c % 300) < 60) ev_ready = ($urandom_range(0, 7) == 0);
                else                ev_ready = ($urandom_range(0, 3) != 0);
                Reset_n = ($urandom_range(0, 299) != 0);
                tick(1);
            end
            Reset_n = 1'b1;
            tick(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
